// File: rtl/cv32e40p_instr_fetch_fifo.sv
// Instruction fetch FIFO between instruction memory and decode.
// Optional macro CV32E40P_FETCH_FIFO_FALLTHROUGH_EN lets a word bypass an empty FIFO combinationally.
module cv32e40p_instr_fetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [31:0]              in_rdata_i,
  input  logic [31:0]              in_addr_i,
  input  logic                     in_err_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              out_rdata_o,
  output logic [31:0]              out_addr_o,
  output logic                     out_err_o,
  output logic [$clog2(DEPTH):0]   cnt_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;

  logic [31:0]      r_mem_rdata [DEPTH];
  logic [31:0]      r_mem_addr  [DEPTH];
  logic             r_mem_err   [DEPTH];

  logic             w_empty;
  logic             w_full;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;

  assign w_empty    = (r_cnt == '0);
  assign w_full     = (r_cnt == CNT_W'(DEPTH));
  assign empty_o    = w_empty;
  assign full_o     = w_full;
  assign cnt_o      = r_cnt;
  assign in_ready_o = !w_full;

`ifdef CV32E40P_FETCH_FIFO_FALLTHROUGH_EN
  logic w_fallthrough;
  // An empty FIFO presents the incoming word directly; if decode takes it, it is never stored.
  assign w_fallthrough = w_empty && in_valid_i && !flush_i;
  assign w_bypass      = w_fallthrough && out_ready_i;
  assign out_valid_o   = (!w_empty && !flush_i) || w_fallthrough;
  assign out_rdata_o   = w_fallthrough ? in_rdata_i : r_mem_rdata[r_rptr];
  assign out_addr_o    = w_fallthrough ? in_addr_i  : r_mem_addr[r_rptr];
  assign out_err_o     = w_fallthrough ? in_err_i   : r_mem_err[r_rptr];
`else
  assign w_bypass      = 1'b0;
  assign out_valid_o   = !w_empty && !flush_i;
  assign out_rdata_o   = r_mem_rdata[r_rptr];
  assign out_addr_o    = r_mem_addr[r_rptr];
  assign out_err_o     = r_mem_err[r_rptr];
`endif

  assign w_push = in_valid_i && !w_full && !flush_i && !w_bypass;
  assign w_pop  = !w_empty && out_ready_i && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by the control state alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rdata[r_wptr] <= in_rdata_i;
      r_mem_addr[r_wptr]  <= in_addr_i;
      r_mem_err[r_wptr]   <= in_err_i;
    end
  end

endmodule

// File: tb/tb_cv32e40p_instr_fetch_fifo.sv
// Scoreboard bench for cv32e40p_instr_fetch_fifo: a queue model of the FIFO contents,
// directed scenarios followed by randomized traffic.
module tb_cv32e40p_instr_fetch_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [31:0]   in_rdata_i = '0;
  logic [31:0]   in_addr_i = '0;
  logic          in_err_i = 1'b0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [31:0]   out_rdata_o;
  logic [31:0]   out_addr_o;
  logic          out_err_o;
  logic [CW-1:0] cnt_o;
  logic          empty_o;
  logic          full_o;

  cv32e40p_instr_fetch_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_rdata_i(in_rdata_i), .in_addr_i(in_addr_i), .in_err_i(in_err_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_rdata_o(out_rdata_o), .out_addr_o(out_addr_o), .out_err_o(out_err_o),
    .cnt_o(cnt_o), .empty_o(empty_o), .full_o(full_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [31:0] a;
    logic        e;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  bit   pend_pop = 1'b0;
  bit   bypass = 1'b0;
  int   occ;
  int   exp_cnt;
  bit   exp_valid;
  bit   ft;
  ent_t e_new;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue of accepted words, bounded by DEPTH.
  always @(posedge clk) begin
    if (rst_n) begin
      occ = q.size() + int'(pend_pop);
      if (flush_i) q.delete();
      else if (in_valid_i && occ < DEPTH && !bypass) begin
        e_new.d = in_rdata_i;
        e_new.a = in_addr_i;
        e_new.e = in_err_i;
        q.push_back(e_new);
      end
    end
    pend_pop = 1'b0;
    bypass   = 1'b0;
  end

  // Monitor: compare visible state against the model and retire handshaken words.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      exp_cnt = q.size();
      ft = 1'b0;
`ifdef CV32E40P_FETCH_FIFO_FALLTHROUGH_EN
      ft = (exp_cnt == 0) && in_valid_i && !flush_i;
`endif
      exp_valid = ((exp_cnt != 0) && !flush_i) || ft;
      check("cnt", 64'(cnt_o), 64'(exp_cnt));
      check("full", 64'(full_o), 64'(exp_cnt == DEPTH));
      check("empty", 64'(empty_o), 64'(exp_cnt == 0));
      check("in_ready", 64'(in_ready_o), 64'(exp_cnt != DEPTH));
      check("out_valid", 64'(out_valid_o), 64'(exp_valid));
      if (ft) begin
        check("ft_rdata", 64'(out_rdata_o), 64'(in_rdata_i));
        check("ft_addr", 64'(out_addr_o), 64'(in_addr_i));
        check("ft_err", 64'(out_err_o), 64'(in_err_i));
        if (out_ready_i) bypass = 1'b1;
      end else if (exp_valid) begin
        check("rdata", 64'(out_rdata_o), 64'(q[0].d));
        check("addr", 64'(out_addr_o), 64'(q[0].a));
        check("err", 64'(out_err_o), 64'(q[0].e));
        if (out_ready_i) begin
          void'(q.pop_front());
          pend_pop = 1'b1;
        end
      end
    end
  end

  task automatic drive(input bit v, input bit rdy, input bit fl,
                       input logic [31:0] d, input logic [31:0] a, input bit e);
    @(posedge clk);
    #1;
    in_valid_i  = v;
    out_ready_i = rdy;
    flush_i     = fl;
    in_rdata_i  = d;
    in_addr_i   = a;
    in_err_i    = e;
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, rdy, 1'b0, $urandom, $urandom, 1'b0);
  endtask

  task automatic check_reset_state();
    check("rst_cnt", 64'(cnt_o), 64'(0));
    check("rst_empty", 64'(empty_o), 64'(1));
    check("rst_full", 64'(full_o), 64'(0));
    check("rst_out_valid", 64'(out_valid_o), 64'(0));
    check("rst_in_ready", 64'(in_ready_o), 64'(1));
  endtask

  initial begin
    // Power-on reset
    #2;
    check_reset_state();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // Single word at PC 0x80, held at the head
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0013, 32'h80, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("first_valid", 64'(out_valid_o), 64'(1));
    check("first_rdata", 64'(out_rdata_o), 64'h13);
    check("first_addr", 64'(out_addr_o), 64'h80);
    idle(1'b1, 3);

    // Fill to full, offer a 5th word, then pop one
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 1'b0, $urandom, 32'h100 + 4 * i, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1F0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1F4, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("ready_after_pop", 64'(in_ready_o), 64'(1));
    idle(1'b1, DEPTH + 2);

    // Ten words streamed with both handshakes held high
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0, $urandom, 32'h80 + 4 * i, 1'b0);
    idle(1'b1, 3);

    // Three stored, then flush together with a push
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, $urandom, 32'h200 + 4 * i, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 32'hBAD0_BAD0, 32'h2F0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("flush_cnt", 64'(cnt_o), 64'(0));
    check("flush_valid", 64'(out_valid_o), 64'(0));
    idle(1'b1, 3);

    // Bus error flagged only on the second word
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, $urandom, 32'h300 + 4 * i, i == 1);
    idle(1'b0, 1);
    idle(1'b1, 5);

    // Reset asserted in the middle of a fill
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b0, $urandom, 32'h400 + 4 * i, 1'b0);
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    rst_n = 1'b0;
    q.delete();
    #1;
    check_reset_state();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
            $urandom, $urandom, $urandom_range(0, 7) == 0);
    idle(1'b1, DEPTH + 2);

    @(negedge clk);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/cv32e40p_instr_fetch_fifo.md
CV32E40P_INSTR_FETCH_FIFO -- requirements
Module: cv32e40p_instr_fetch_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of entries; must be a power of two and at least 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port flush_i, input, 1 bit: discards all stored entries, e.g. on branch, jump or exception.
REQ-005 SHALL have port in_valid_i, input, 1 bit: an instruction-memory response word is present.
REQ-006 SHALL have port in_ready_o, output, 1 bit: the FIFO can accept a word.
REQ-007 SHALL have port in_rdata_i, input, 32 bits: the fetched instruction word.
REQ-008 SHALL have port in_addr_i, input, 32 bits: the PC of the fetched word.
REQ-009 SHALL have port in_err_i, input, 1 bit: bus error on the fetch.
REQ-010 SHALL have port out_valid_o, output, 1 bit: the head entry is presented to the decode stage.
REQ-011 SHALL have port out_ready_i, input, 1 bit: the decode stage consumes the head this cycle.
REQ-012 SHALL have port out_rdata_o, output, 32 bits: the head instruction word.
REQ-013 SHALL have port out_addr_o, output, 32 bits: the head PC.
REQ-014 SHALL have port out_err_o, output, 1 bit: the head bus-error flag.
REQ-015 SHALL have port cnt_o, output, $clog2(DEPTH)+1 bits: the number of stored entries.
REQ-016 SHALL have port empty_o, output, 1 bit: cnt_o == 0.
REQ-017 SHALL have port full_o, output, 1 bit: cnt_o == DEPTH.

Function
REQ-018 SHALL drive in_ready_o = !full_o, independent of out_ready_i.
REQ-019 SHALL define push = in_valid_i && in_ready_o && !flush_i, and pop = out_valid_o && out_ready_i && !flush_i.
REQ-020 SHALL store {rdata, addr, err} at the write pointer on a push; the write pointer SHALL increment modulo DEPTH.
REQ-021 SHALL increment the read pointer modulo DEPTH on a pop; pointers SHALL wrap from DEPTH-1 to 0 with no bubble.
REQ-022 SHALL update cnt_o as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-023 SHALL drive out_valid_o = !empty_o && !flush_i, with out_* taken from the entry at the read pointer (registered path).
REQ-024 SHALL give a latency of one cycle from push to out_valid_o when the FIFO is empty (fall-through not compiled).
REQ-025 SHALL, on flush_i, zero cnt_o and both pointers at the next edge and drop any push in the same cycle; flush_i has priority over push and pop.
REQ-026 SHALL NOT push when full, even with out_ready_i high; words SHALL leave strictly in arrival order.
REQ-027 SHALL assert in_ready_o in the cycle after a pop from the full state.
REQ-028 SHALL leave entry payload registers unreset; only control state is reset.

Reset
REQ-029 SHALL, while rst_n is low, immediately force cnt_o = 0, both pointers = 0, empty_o = 1, full_o = 0, out_valid_o = 0 and in_ready_o = 1.
REQ-030 SHALL, on reset asserted mid-stream, lose all stored entries, with no push or pop on the release edge unless the handshake holds.

Configuration
REQ-031 SHALL, with macro CV32E40P_FETCH_FIFO_FALLTHROUGH_EN defined, drive out_valid_o = 1 and out_* = in_* combinationally when empty and in_valid_i && !flush_i.
REQ-032 SHALL, in fall-through mode with out_ready_i high in that cycle, consume the word without storing it: cnt_o is unchanged and both pointers are unchanged.
REQ-033 SHALL, with the macro undefined, follow REQ-023/REQ-024 exactly and have no combinational path from in_* to out_*.

Verification
REQ-034 SHALL cover: reset, then push 0x00000013 @PC 0x80 -> out_valid_o=1 next cycle, out_rdata_o=0x00000013, out_addr_o=0x80, cnt_o=1.
REQ-035 SHALL cover: DEPTH=4, push 4 words with out_ready_i=0 -> full_o=1, in_ready_o=0; a 5th word is not accepted; pop one -> in_ready_o=1 next cycle.
REQ-036 SHALL cover: 10 words streamed with in_valid_i=out_ready_i=1 -> outputs in order, PCs 0x80..0xA4, pointers wrap, cnt_o stays at 1 at most.
REQ-037 SHALL cover: 3 entries stored, flush_i=1 together with a push -> next cycle cnt_o=0, out_valid_o=0, and the pushed word never appears.
REQ-038 SHALL cover: in_err_i=1 on the 2nd word -> out_err_o=1 only while that word is at the head.
REQ-039 SHALL cover: fall-through build, empty, in_valid_i=out_ready_i=1 -> out_valid_o=1 in the same cycle with out_rdata_o=in_rdata_i, cnt_o stays 0; rst_n pulsed low mid-fill -> cnt_o=0 immediately.
